// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath register file: widths, the
// hard-wired zero register index and the debug write-counter width.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;
  localparam int CNT_W    = 16;

  localparam int DEPTH    = 1 << ADDR_W;

  // Saturating increment used by the debug counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    result = value;
    if (value != {CNT_W{1'b1}}) begin
      result = value + CNT_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: array select, register-zero check and
// same-cycle write forwarding. Unknown addresses fall through to zero.
module rf_read_port #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              active,
  input  logic [DATA_W-1:0] regs [1 << ADDR_W],
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  import mips_pkg::*;

  localparam int PORT_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] sel;
  logic              addr_nonzero;
  logic              fwd;

  // Compare-and-select rather than an indexed read: an x on addr makes every
  // compare fail, so sel stays zero instead of propagating x.
  always_comb begin
    sel = '0;
    for (int i = 0; i < PORT_DEPTH; i++) begin
      if (addr == ADDR_W'(i)) begin
        sel = regs[i];
      end
    end
  end

  always_comb begin
    addr_nonzero = 1'b0;
    if (addr != ADDR_W'(REG_ZERO)) begin
      addr_nonzero = 1'b1;
    end
  end

  always_comb begin
    fwd = 1'b0;
    if (active && we && (waddr != ADDR_W'(REG_ZERO)) && (waddr == addr)) begin
      fwd = 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (!active) begin
      rdata = '0;
    end else if (fwd) begin
      rdata = wdata;
    end else if (addr_nonzero) begin
      rdata = sel;
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32-entry register file with two forwarding read ports, a hard-wired zero
// register and a saturating count of committed writes.
module reg_file #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [15:0]       WriteCount
);

  import mips_pkg::*;

  localparam int RF_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [RF_DEPTH];
  logic [CNT_W-1:0]  count;
  logic              commit;

  always_comb begin
    commit = 1'b0;
    if (RegWrite && (WriteReg != ADDR_W'(REG_ZERO))) begin
      commit = 1'b1;
    end
  end

  // Register zero is cleared by reset and never written, so it reads as zero
  // even before the read-port zero check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[WriteReg] <= WriteData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (commit) begin
      count <= sat_inc(count);
    end
  end

  assign WriteCount = count;

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_port1 (
    .active (rst_n),
    .regs   (regs),
    .addr   (ReadReg1),
    .we     (RegWrite),
    .waddr  (WriteReg),
    .wdata  (WriteData),
    .rdata  (ReadData1)
  );

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_port2 (
    .active (rst_n),
    .regs   (regs),
    .addr   (ReadReg2),
    .we     (RegWrite),
    .waddr  (WriteReg),
    .wdata  (WriteData),
    .rdata  (ReadData2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset behaviour, write/read, register zero,
// forwarding, write-enable gating and counter saturation.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          RegWrite;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData;
  logic [AW-1:0] ReadReg1;
  logic [AW-1:0] ReadReg2;
  logic [DW-1:0] ReadData1;
  logic [DW-1:0] ReadData2;
  logic [15:0]   WriteCount;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [15:0] exp_cnt = '0;

  logic [AW-1:0] vec_addr [4];
  logic [DW-1:0] vec_data [4];

  // Clock / reset
  always #5 clk = ~clk;

  reg_file #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RegWrite   (RegWrite),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .ReadReg1   (ReadReg1),
    .ReadReg2   (ReadReg2),
    .ReadData1  (ReadData1),
    .ReadData2  (ReadData2),
    .WriteCount (WriteCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: one write cycle, inputs change 1 time unit after the active edge.
  task automatic write_cycle(input logic [AW-1:0] a, input logic [DW-1:0] d);
    RegWrite  = 1'b1;
    WriteReg  = a;
    WriteData = d;
    @(posedge clk);
    #1;
    RegWrite  = 1'b0;
    if (a != '0 && exp_cnt != 16'hFFFF) begin
      exp_cnt = exp_cnt + 16'd1;
    end
  endtask

  task automatic read_pair(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    ReadReg1 = a1;
    ReadReg2 = a2;
    #1;
  endtask

  initial begin
    vec_addr[0] = 5'd1;  vec_data[0] = 32'h0000_0001;
    vec_addr[1] = 5'd2;  vec_data[1] = 32'h8000_0000;
    vec_addr[2] = 5'd31; vec_data[2] = 32'h1357_9BDF;
    vec_addr[3] = 5'd17; vec_data[3] = 32'hCAFE_F00D;

    rst_n     = 1'b0;
    RegWrite  = 1'b0;
    WriteReg  = '0;
    WriteData = '0;
    ReadReg1  = '0;
    ReadReg2  = '0;
    #2;
    check("reset_rd1", ReadData1, 32'h0);
    check("reset_rd2", ReadData2, 32'h0);
    check("reset_cnt", {16'h0, WriteCount}, 32'h0);

    // Forwarding is suppressed and the edge is ignored while in reset.
    RegWrite  = 1'b1;
    WriteReg  = 5'd3;
    WriteData = 32'h5555_5555;
    read_pair(5'd3, 5'd3);
    check("reset_nofwd_rd1", ReadData1, 32'h0);
    check("reset_nofwd_rd2", ReadData2, 32'h0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    read_pair(5'd3, 5'd3);
    check("reset_edge_ignored", ReadData1, 32'h0);
    check("reset_edge_cnt", {16'h0, WriteCount}, 32'h0);

    // First edge after deassert accepts the write.
    write_cycle(5'd8, 32'hDEAD_BEEF);
    read_pair(5'd8, 5'd0);
    check("basic_rd1", ReadData1, 32'hDEAD_BEEF);
    check("basic_rd2_r0", ReadData2, 32'h0);
    check("basic_cnt", {16'h0, WriteCount}, {16'h0, exp_cnt});

    for (int i = 0; i < 4; i++) begin
      write_cycle(vec_addr[i], vec_data[i]);
    end
    for (int i = 0; i < 4; i++) begin
      read_pair(vec_addr[i], vec_addr[3 - i]);
      check("table_rd1", ReadData1, vec_data[i]);
      check("table_rd2", ReadData2, vec_data[3 - i]);
    end
    read_pair(5'd17, 5'd17);
    check("same_addr_rd1", ReadData1, 32'hCAFE_F00D);
    check("same_addr_rd2", ReadData2, 32'hCAFE_F00D);
    check("table_cnt", {16'h0, WriteCount}, 32'd5);

    // Register zero.
    write_cycle(5'd0, 32'hFFFF_FFFF);
    read_pair(5'd0, 5'd0);
    check("r0_rd1", ReadData1, 32'h0);
    check("r0_rd2", ReadData2, 32'h0);
    check("r0_cnt", {16'h0, WriteCount}, 32'd5);
    RegWrite  = 1'b1;
    WriteReg  = 5'd0;
    WriteData = 32'h1234_5678;
    read_pair(5'd0, 5'd8);
    check("r0_nofwd", ReadData1, 32'h0);
    RegWrite = 1'b0;

    // Forwarding before the edge.
    RegWrite  = 1'b1;
    WriteReg  = 5'd3;
    WriteData = 32'hA5A5_A5A5;
    read_pair(5'd3, 5'd3);
    check("fwd_rd1", ReadData1, 32'hA5A5_A5A5);
    check("fwd_rd2", ReadData2, 32'hA5A5_A5A5);
    read_pair(5'd3, 5'd8);
    check("fwd_other_port", ReadData2, 32'hDEAD_BEEF);
    write_cycle(5'd3, 32'hA5A5_A5A5);
    read_pair(5'd3, 5'd3);
    check("fwd_stored", ReadData1, 32'hA5A5_A5A5);
    RegWrite  = 1'b1;
    WriteReg  = 5'd8;
    WriteData = 32'h0000_0011;
    read_pair(5'd3, 5'd8);
    check("fwd_override", ReadData2, 32'h0000_0011);
    check("fwd_no_leak", ReadData1, 32'hA5A5_A5A5);
    RegWrite = 1'b0;
    read_pair(5'd3, 5'd8);
    check("fwd_drop_we", ReadData2, 32'hDEAD_BEEF);
    check("fwd_cnt", {16'h0, WriteCount}, 32'd6);

    // RegWrite=0 leaves state untouched.
    write_cycle(5'd9, 32'h0000_0099);
    RegWrite  = 1'b0;
    WriteReg  = 5'd9;
    WriteData = 32'd7;
    read_pair(5'd9, 5'd9);
    check("we0_pre_edge", ReadData1, 32'h0000_0099);
    @(posedge clk);
    #1;
    read_pair(5'd9, 5'd9);
    check("we0_retain", ReadData1, 32'h0000_0099);
    check("we0_cnt", {16'h0, WriteCount}, 32'd7);

    // Mid-cycle asynchronous reset.
    write_cycle(5'd5, 32'h0000_1234);
    read_pair(5'd5, 5'd8);
    check("pre_reset_r5", ReadData1, 32'h0000_1234);
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    check("async_reset_r5", ReadData1, 32'h0);
    check("async_reset_r8", ReadData2, 32'h0);
    check("async_reset_cnt", {16'h0, WriteCount}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    read_pair(5'd5, 5'd9);
    check("post_reset_r5", ReadData1, 32'h0);
    check("post_reset_r9", ReadData2, 32'h0);

    // Saturation: 65537 committed writes.
    for (int i = 0; i < 65534; i++) begin
      write_cycle(5'd1, DW'(i));
    end
    check("sat_fffe", {16'h0, WriteCount}, 32'h0000_FFFE);
    write_cycle(5'd1, DW'(65534));
    check("sat_ffff", {16'h0, WriteCount}, 32'h0000_FFFF);
    write_cycle(5'd1, DW'(65535));
    write_cycle(5'd1, DW'(65536));
    check("sat_hold", {16'h0, WriteCount}, 32'h0000_FFFF);
    check("sat_model", {16'h0, WriteCount}, {16'h0, exp_cnt});
    read_pair(5'd1, 5'd1);
    check("sat_last_data", ReadData1, 32'h0001_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width; depth is 2^ADDR_W = 32.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset; asynchronous and active-low.
REQ-005 SHALL have port RegWrite, input, 1, meaning write enable.
REQ-006 SHALL have port WriteReg, input, ADDR_W, meaning write address; driven by the upstream 5-bit RegDst 2:1 select (rt/rd).
REQ-007 SHALL have port WriteData, input, DATA_W, meaning write data.
REQ-008 SHALL have ports ReadReg1 and ReadReg2, input, ADDR_W each, meaning read addresses (rs, rt).
REQ-009 SHALL have ports ReadData1 and ReadData2, output, DATA_W each, meaning read data.
REQ-010 SHALL have port WriteCount, output, 16, meaning a saturating count of committed writes, for debug.

Function
REQ-011 SHALL hold 32 registers of DATA_W bits each.
REQ-012 SHALL write WriteData into register[WriteReg] on the rising clk edge when RegWrite=1 and WriteReg!=0; write latency is 1 edge.
REQ-013 SHALL ignore writes to register 0; register 0 SHALL always read 0.
REQ-014 SHALL read combinationally: ReadDataN = register[ReadRegN] with zero added latency.
REQ-015 SHALL forward internally: when RegWrite=1, WriteReg!=0 and WriteReg==ReadRegN in the same cycle, ReadDataN SHALL equal WriteData (write-before-read).
REQ-016 SHALL let both read ports address the same register simultaneously, each returning an identical value.
REQ-017 SHALL increment WriteCount by 1 per committed write (RegWrite=1, WriteReg!=0); it SHALL saturate at 16'hFFFF with no wrap-around.
REQ-018 SHALL not count writes to register 0.
REQ-019 SHALL have only X-free outputs: unknown select paths SHALL resolve to 0, never to x.
REQ-020 SHALL treat WriteReg and WriteData as don't-care when RegWrite=0; no state changes.

Reset
REQ-021 SHALL clear all 32 registers and WriteCount to 0 immediately when rst_n falls, without waiting for clk.
REQ-022 SHALL give ReadData1 and ReadData2 the value 0 while rst_n=0, and SHALL suppress forwarding during reset.
REQ-023 SHALL ignore a write whose clock edge coincides with rst_n=0.
REQ-024 SHALL accept the first write on the first rising clk edge after rst_n deasserts.

Structure
REQ-025 SHALL place DATA_W, ADDR_W, the REG_ZERO=0 constant and the counter width in a shared mips_pkg package.
REQ-026 SHALL use one sub-module, rf_read_port, instantiated twice; it contains the array select, the zero check and the forward mux.
REQ-027 SHALL keep the storage array and write logic in reg_file itself.

Verification
REQ-028 SHALL cover reset: pulse rst_n low mid-cycle after writing R5=32'h1234 -> R5 reads 0 immediately and WriteCount=0.
REQ-029 SHALL cover basic write/read: RegWrite=1, WriteReg=8, WriteData=32'hDEADBEEF, then ReadReg1=8 next cycle -> ReadData1=32'hDEADBEEF.
REQ-030 SHALL cover register 0: write 32'hFFFFFFFF to WriteReg=0 -> ReadData1 (ReadReg1=0) stays 0 and WriteCount is unchanged.
REQ-031 SHALL cover forwarding: same cycle RegWrite=1, WriteReg=3, WriteData=32'hA5A5A5A5, ReadReg1=ReadReg2=3 -> both outputs read 32'hA5A5A5A5 before the edge.
REQ-032 SHALL cover RegWrite=0: WriteReg=9 with WriteData=7 -> R9 retains its prior value and no count is recorded.
REQ-033 SHALL cover saturation: 65537 committed writes -> WriteCount=16'hFFFF.
